// File: rtl/sweep_seq_pkg.sv
// Shared types for sweep_sequencer: run state, register map, configuration
// record used by both the shadow and active copies, and its validity check.
package sweep_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [1:0] ADDR_MIN  = 2'd0;
   localparam logic [1:0] ADDR_MAX  = 2'd1;
   localparam logic [1:0] ADDR_STEP = 2'd2;
   localparam logic [1:0] ADDR_NCYC = 2'd3;

   // Limits are stored as raw 16-bit patterns and interpreted as signed.
   // ncyc is zero-extended from the counter width on write.
   typedef struct packed {
      logic [15:0] minval;
      logic [15:0] maxval;
      logic [31:0] step;
      logic [31:0] ncyc;
   } cfg_t;

   function automatic logic cfg_valid(input cfg_t c);
      return ($signed(c.minval) < $signed(c.maxval)) && (c.step != 32'd0);
   endfunction

endpackage

// File: rtl/sweep_turn_detect.sv
// Turnaround detector: previous-sample register and the seen_top arming flag;
// emits a combinational bottom-event pulse for the sequencer to register.
module sweep_turn_detect (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               i_enable,
   input  logic               i_clear,
   input  logic signed [15:0] i_sample,
   input  logic signed [15:0] i_minval,
   input  logic signed [15:0] i_maxval,
   output logic               o_bottom
);

   logic signed [15:0] r_prev;
   logic               r_seen_top;
   logic               w_top;
   logic               w_bottom;

   assign w_top    = i_enable && (i_sample == i_maxval) && (r_prev != i_maxval);
   // A bottom only counts once the top has been reached, so a sweep that
   // starts at 0 with minval = 0 does not produce a spurious trigger.
   assign w_bottom = i_enable && (i_sample == i_minval) && (r_prev != i_minval)
                     && r_seen_top;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_prev     <= '0;
         r_seen_top <= 1'b0;
      end else begin
         r_prev <= i_sample;
         if (i_clear)
            r_seen_top <= 1'b0;
         else if (w_top)
            r_seen_top <= 1'b1;
         else if (w_bottom)
            r_seen_top <= 1'b0;
      end
   end

   assign o_bottom = w_bottom;

endmodule

// File: rtl/sweep_sequencer.sv
// Run controller for one Sweep instance: shadow/active configuration,
// turnaround-aligned updates, period counting, trigger and done pulses.
module sweep_sequencer
   import sweep_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               cfg_we_in,
   input  logic [1:0]         cfg_addr_in,
   input  logic [31:0]        cfg_data_in,
   input  logic               start_in,
   input  logic               stop_in,
   input  logic signed [15:0] sweep_signal_in,
   output logic               sweep_on_out,
   output logic signed [15:0] minval_out,
   output logic signed [15:0] maxval_out,
   output logic [31:0]        stepsize_out,
   output logic               busy_out,
   output logic               trig_out,
   output logic               done_out,
   output logic               err_out,
   output logic [CNT_W-1:0]   cycle_count_out
);

   state_t             r_state, w_state_next;
   cfg_t               r_shadow, w_shadow_next;
   cfg_t               r_active, w_active_next;
   logic               r_pending, w_pending_next;
   logic [CNT_W-1:0]   r_count, w_count_next;
   logic               r_trig, w_trig_next;
   logic               r_done, w_done_next;
   logic               r_err, w_err_next;
   logic               w_run;
   logic               w_bottom;
   logic               w_start_ok;
   logic               w_limit_hit;
   logic [CNT_W-1:0]   w_count_inc;

   assign w_run       = (r_state == ST_RUN);
   assign w_start_ok  = !w_run && start_in && !stop_in && cfg_valid(r_shadow);
   assign w_count_inc = r_count + CNT_W'(1);
   assign w_limit_hit = (r_active.ncyc != 32'd0) && (32'(w_count_inc) == r_active.ncyc);

   sweep_turn_detect u_turn (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .i_enable (w_run),
      .i_clear  (w_start_ok),
      .i_sample (sweep_signal_in),
      .i_minval (minval_out),
      .i_maxval (maxval_out),
      .o_bottom (w_bottom)
   );

   always_comb begin
      w_state_next   = r_state;
      w_shadow_next  = r_shadow;
      w_active_next  = r_active;
      w_pending_next = r_pending | cfg_we_in;
      w_count_next   = r_count;
      w_trig_next    = 1'b0;
      w_done_next    = 1'b0;
      w_err_next     = 1'b0;

      if (cfg_we_in) begin
         case (cfg_addr_in)
            ADDR_MIN:  w_shadow_next.minval = cfg_data_in[15:0];
            ADDR_MAX:  w_shadow_next.maxval = cfg_data_in[15:0];
            ADDR_STEP: w_shadow_next.step   = cfg_data_in;
            default:   w_shadow_next.ncyc   = 32'(cfg_data_in[CNT_W-1:0]);
         endcase
      end

      // Copies always take the pre-write shadow; a write landing in the same
      // cycle leaves pending set so it is picked up at the next turnaround.
      unique case (r_state)
         ST_IDLE: begin
            if (start_in && !stop_in) begin
               if (w_start_ok) begin
                  w_active_next  = r_shadow;
                  w_count_next   = '0;
                  w_pending_next = cfg_we_in;
                  w_state_next   = ST_RUN;
               end else begin
                  w_err_next = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (w_bottom) begin
               w_count_next = w_count_inc;
               w_trig_next  = 1'b1;
               if (!stop_in) begin
                  if (w_limit_hit) begin
                     w_done_next  = 1'b1;
                     w_state_next = ST_IDLE;
                  end else if (r_pending) begin
                     if (cfg_valid(r_shadow))
                        w_active_next = r_shadow;
                     else
                        w_err_next = 1'b1;
                     w_pending_next = cfg_we_in;
                  end
               end
            end
            if (stop_in)
               w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state   <= ST_IDLE;
         r_shadow  <= '0;
         r_active  <= '0;
         r_pending <= 1'b0;
         r_count   <= '0;
         r_trig    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_shadow  <= w_shadow_next;
         r_active  <= w_active_next;
         r_pending <= w_pending_next;
         r_count   <= w_count_next;
         r_trig    <= w_trig_next;
         r_done    <= w_done_next;
         r_err     <= w_err_next;
      end
   end

   assign sweep_on_out    = w_run;
   assign busy_out        = w_run;
   assign minval_out      = r_active.minval;
   assign maxval_out      = r_active.maxval;
   assign stepsize_out    = r_active.step;
   assign trig_out        = r_trig;
   assign done_out        = r_done;
   assign err_out         = r_err;
   assign cycle_count_out = r_count;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: vector table, directed corner sequences and
// randomized traffic against a rule-level reference model and a triangle plant.
module tb_sweep_sequencer;
   import sweep_seq_pkg::*;

   localparam int CNT_W = 16;

   logic               clk_in = 1'b0;
   logic               rst_n_in;
   logic               cfg_we_in;
   logic [1:0]         cfg_addr_in;
   logic [31:0]        cfg_data_in;
   logic               start_in;
   logic               stop_in;
   logic signed [15:0] sweep_signal_in;
   logic               sweep_on_out;
   logic signed [15:0] minval_out;
   logic signed [15:0] maxval_out;
   logic [31:0]        stepsize_out;
   logic               busy_out;
   logic               trig_out;
   logic               done_out;
   logic               err_out;
   logic [CNT_W-1:0]   cycle_count_out;

   int total = 0;
   int bad   = 0;

   sweep_sequencer #(.CNT_W(CNT_W)) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .cfg_we_in       (cfg_we_in),
      .cfg_addr_in     (cfg_addr_in),
      .cfg_data_in     (cfg_data_in),
      .start_in        (start_in),
      .stop_in         (stop_in),
      .sweep_signal_in (sweep_signal_in),
      .sweep_on_out    (sweep_on_out),
      .minval_out      (minval_out),
      .maxval_out      (maxval_out),
      .stepsize_out    (stepsize_out),
      .busy_out        (busy_out),
      .trig_out        (trig_out),
      .done_out        (done_out),
      .err_out         (err_out),
      .cycle_count_out (cycle_count_out)
   );

   always #5 clk_in = ~clk_in;

   // Reference model state: what the sequencer should be showing.
   bit                 m_run, m_pend, m_trig, m_done, m_err, m_seen;
   logic signed [15:0] sh_min, sh_max, ac_min, ac_max, m_prev;
   logic [31:0]        sh_step, ac_step;
   logic [15:0]        sh_ncyc, ac_ncyc, m_cnt;
   bit                 use_plant;
   bit                 chk_model;
   int                 p_dir;

   typedef struct {
      logic               we;
      logic [1:0]         addr;
      logic [31:0]        data;
      logic               start;
      logic               stop;
      logic signed [15:0] sig;
      logic               on, trig, done, err;
      logic signed [15:0] mn, mx;
      logic [15:0]        cnt;
   } vec_t;
   vec_t tq[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_pend = 0; m_trig = 0; m_done = 0; m_err = 0; m_seen = 0;
      sh_min = 0; sh_max = 0; ac_min = 0; ac_max = 0; m_prev = 0;
      sh_step = 0; ac_step = 0; sh_ncyc = 0; ac_ncyc = 0; m_cnt = 0;
   endtask

   task automatic copy_cfg();
      ac_min = sh_min; ac_max = sh_max; ac_step = sh_step; ac_ncyc = sh_ncyc;
   endtask

   // One clock edge of the rules: events on the sampled signal, then the
   // run/idle decisions, then the host write lands in the shadow.
   task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d,
                             input logic st, input logic sp, input logic signed [15:0] sig);
      bit valid, top, bot;
      valid  = (sh_min < sh_max) && (sh_step != 0);
      top    = m_run && (sig == ac_max) && (m_prev != ac_max);
      bot    = m_run && (sig == ac_min) && (m_prev != ac_min) && m_seen;
      m_trig = 0; m_done = 0; m_err = 0;
      if (m_run) begin
         if (top) m_seen = 1;
         else if (bot) m_seen = 0;
         if (bot) begin
            m_cnt  = m_cnt + 16'd1;
            m_trig = 1;
            if (!sp) begin
               if (ac_ncyc != 0 && m_cnt == ac_ncyc) begin
                  m_done = 1;
                  m_run  = 0;
               end else if (m_pend) begin
                  if (valid) copy_cfg();
                  else m_err = 1;
                  m_pend = 0;
               end
            end
         end
         if (sp) m_run = 0;
      end else if (st && !sp) begin
         if (valid) begin
            copy_cfg();
            m_cnt = 0; m_seen = 0; m_pend = 0; m_run = 1;
         end else begin
            m_err = 1;
         end
      end
      m_prev = sig;
      if (we) begin
         case (a)
            2'd0: sh_min = d[15:0];
            2'd1: sh_max = d[15:0];
            2'd2: sh_step = d;
            default: sh_ncyc = d[15:0];
         endcase
         m_pend = 1;
      end
   endtask

   // Stand-in for Sweep: triangle between the active limits, 0 while off.
   task automatic plant_step();
      int dlt, s;
      if (!use_plant) return;
      dlt = int'(ac_step[31:16]);
      if (dlt == 0) dlt = 1;
      if (!m_run) begin
         sweep_signal_in = 0;
         p_dir = 1;
      end else begin
         s = sweep_signal_in;
         if (p_dir > 0) begin
            s = s + dlt;
            if (s >= ac_max) begin s = ac_max; p_dir = -1; end
         end else begin
            s = s - dlt;
            if (s <= ac_min) begin s = ac_min; p_dir = 1; end
         end
         sweep_signal_in = 16'(s);
      end
   endtask

   task automatic tick();
      logic c_we, c_st, c_sp;
      logic [1:0] c_a;
      logic [31:0] c_d;
      logic signed [15:0] c_sig;
      logic [84:0] act, exp;
      c_we = cfg_we_in; c_a = cfg_addr_in; c_d = cfg_data_in;
      c_st = start_in; c_sp = stop_in; c_sig = sweep_signal_in;
      @(posedge clk_in);
      model_edge(c_we, c_a, c_d, c_st, c_sp, c_sig);
      #1;
      if (chk_model) begin
         act = {sweep_on_out, busy_out, trig_out, done_out, err_out,
                minval_out, maxval_out, stepsize_out, cycle_count_out};
         exp = {m_run, m_run, m_trig, m_done, m_err, ac_min, ac_max, ac_step, m_cnt};
         chk("model", act, exp);
      end
      plant_step();
   endtask

   task automatic drive(input logic we, input logic [1:0] a, input logic [31:0] d,
                        input logic st, input logic sp);
      cfg_we_in = we; cfg_addr_in = a; cfg_data_in = d; start_in = st; stop_in = sp;
      tick();
      cfg_we_in = 0; start_in = 0; stop_in = 0;
   endtask

   task automatic wr(input logic [1:0] a, input int d);
      drive(1'b1, a, 32'(d), 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n_in = 0; cfg_we_in = 0; cfg_addr_in = 0; cfg_data_in = 0;
      start_in = 0; stop_in = 0; sweep_signal_in = 0;
      repeat (2) @(posedge clk_in);
      #1;
      model_reset();
      p_dir = 1;
      rst_n_in = 1;
   endtask

   function automatic bit bottom_imminent();
      return m_run && (sweep_signal_in == ac_min) && (m_prev != ac_min) && m_seen;
   endfunction

   task automatic add_vec(input logic we, input int a, input int d, input logic st,
                          input logic sp, input int sig, input logic on, input logic tr,
                          input logic dn, input logic er, input int mn, input int mx,
                          input int cnt);
      vec_t v;
      v.we = we; v.addr = 2'(a); v.data = 32'(d); v.start = st; v.stop = sp;
      v.sig = 16'(sig); v.on = on; v.trig = tr; v.done = dn; v.err = er;
      v.mn = 16'(mn); v.mx = 16'(mx); v.cnt = 16'(cnt);
      tq.push_back(v);
   endtask

   initial begin
      int trigs, cnt_at;
      bit got, trig_at, on_at, early_bad, hit;
      logic signed [15:0] mx_at, mn_at;
      logic [51:0] vact, vexp;

      rst_n_in = 0; cfg_we_in = 0; cfg_addr_in = 0; cfg_data_in = 0;
      start_in = 0; stop_in = 0; sweep_signal_in = 0;
      use_plant = 0; chk_model = 0; p_dir = 1;
      model_reset();
      @(posedge clk_in);
      #1;
      chk("reset_state", {sweep_on_out, busy_out, trig_out, done_out, err_out, minval_out,
                          maxval_out, stepsize_out, cycle_count_out}, 0);

      // Table: min=0 bottom suppression, stop, and both invalid-config starts.
      do_reset();
      add_vec(1, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0, 0,   0);
      add_vec(1, 1, 500, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0);
      add_vec(1, 2, 1,   0, 0, 0,   0, 0, 0, 0, 0, 0,   0);
      add_vec(1, 3, 0,   0, 0, 0,   0, 0, 0, 0, 0, 0,   0);
      add_vec(0, 0, 0,   1, 0, 0,   1, 0, 0, 0, 0, 500, 0);
      add_vec(0, 0, 0,   0, 0, 0,   1, 0, 0, 0, 0, 500, 0);
      add_vec(0, 0, 0,   0, 0, 7,   1, 0, 0, 0, 0, 500, 0);
      add_vec(0, 0, 0,   0, 0, 0,   1, 0, 0, 0, 0, 500, 0);
      add_vec(0, 0, 0,   0, 0, 250, 1, 0, 0, 0, 0, 500, 0);
      add_vec(0, 0, 0,   0, 0, 500, 1, 0, 0, 0, 0, 500, 0);
      add_vec(0, 0, 0,   0, 0, 250, 1, 0, 0, 0, 0, 500, 0);
      add_vec(0, 0, 0,   0, 0, 0,   1, 1, 0, 0, 0, 500, 1);
      add_vec(0, 0, 0,   0, 0, 0,   1, 0, 0, 0, 0, 500, 1);
      add_vec(0, 0, 0,   0, 1, 0,   0, 0, 0, 0, 0, 500, 1);
      add_vec(1, 0, 100, 0, 0, 0,   0, 0, 0, 0, 0, 500, 1);
      add_vec(1, 1, 100, 0, 0, 0,   0, 0, 0, 0, 0, 500, 1);
      add_vec(0, 0, 0,   1, 0, 0,   0, 0, 0, 1, 0, 500, 1);
      add_vec(0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0, 500, 1);
      add_vec(1, 1, 200, 0, 0, 0,   0, 0, 0, 0, 0, 500, 1);
      add_vec(1, 2, 0,   0, 0, 0,   0, 0, 0, 0, 0, 500, 1);
      add_vec(0, 0, 0,   1, 0, 0,   0, 0, 0, 1, 0, 500, 1);
      add_vec(0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0, 500, 1);
      foreach (tq[i]) begin
         sweep_signal_in = tq[i].sig;
         drive(tq[i].we, tq[i].addr, tq[i].data, tq[i].start, tq[i].stop);
         vact = {sweep_on_out, trig_out, done_out, err_out, minval_out, maxval_out, cycle_count_out};
         vexp = {tq[i].on, tq[i].trig, tq[i].done, tq[i].err, tq[i].mn, tq[i].mx, tq[i].cnt};
         chk($sformatf("vec%0d", i), vact, vexp);
      end

      // Three-period run ending in done.
      do_reset();
      use_plant = 1; chk_model = 1;
      wr(ADDR_MIN, -1000); wr(ADDR_MAX, 1000); wr(ADDR_STEP, 32'h0040_0000); wr(ADDR_NCYC, 3);
      drive(0, 0, 0, 1, 0);
      trigs = 0; got = 0; trig_at = 0; on_at = 1; cnt_at = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         tick();
         if (trig_out) trigs++;
         if (done_out) begin
            got = 1; trig_at = trig_out; on_at = sweep_on_out; cnt_at = int'(cycle_count_out);
         end
      end
      chk("ncyc3_done_seen", got, 1);
      chk("ncyc3_trig_count", trigs, 3);
      chk("ncyc3_done_with_trig", trig_at, 1);
      chk("ncyc3_on_at_done", on_at, 0);
      chk("ncyc3_count", cnt_at, 3);
      tick();
      chk("ncyc3_on_after", sweep_on_out, 0);

      // Free run; maxval change written while rising waits for the bottom.
      wr(ADDR_NCYC, 0);
      drive(0, 0, 0, 1, 0);
      got = 0;
      for (int i = 0; i < 500 && !got; i++) begin
         tick();
         if (trig_out) got = 1;
      end
      chk("free_first_trig", got, 1);
      wr(ADDR_MAX, 2000);
      got = 0; early_bad = 0; mx_at = 0;
      for (int i = 0; i < 1000 && !got; i++) begin
         tick();
         if (trig_out) begin got = 1; mx_at = maxval_out; end
         else if (maxval_out != 16'sd1000) early_bad = 1;
      end
      chk("max_apply_trig", got, 1);
      chk("max_held_until_bottom", early_bad, 0);
      chk("max_applied_at_trig", mx_at, 2000);

      // Write coinciding with an apply: old shadow now, new one next bottom.
      wr(ADDR_MIN, -1500);
      hit = 0; mn_at = 0; trig_at = 0;
      for (int i = 0; i < 1000 && !hit; i++) begin
         if (bottom_imminent()) begin
            wr(ADDR_MIN, -500);
            hit = 1; mn_at = minval_out; trig_at = trig_out;
         end else begin
            tick();
         end
      end
      chk("coincident_write_hit", hit, 1);
      chk("coincident_trig", trig_at, 1);
      chk("coincident_old_applied", mn_at, -1500);
      got = 0; mn_at = 0;
      for (int i = 0; i < 1000 && !got; i++) begin
         tick();
         if (trig_out) begin got = 1; mn_at = minval_out; end
      end
      chk("coincident_next_trig", got, 1);
      chk("coincident_new_applied", mn_at, -500);

      // start+stop together while running: stop wins, no done.
      drive(0, 0, 0, 1, 1);
      chk("stopstart_on", sweep_on_out, 0);
      chk("stopstart_busy", busy_out, 0);
      chk("stopstart_done", done_out, 0);

      // Asynchronous reset in the middle of a run.
      drive(0, 0, 0, 1, 0);
      repeat (15) tick();
      #2 rst_n_in = 0;
      #1;
      chk("async_reset_outputs", {sweep_on_out, busy_out, trig_out, done_out, err_out, minval_out,
                                  maxval_out, stepsize_out, cycle_count_out}, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         logic we_r, st_r, sp_r;
         logic [1:0] a_r;
         int d_r;
         we_r = ($urandom_range(0, 15) == 0);
         a_r  = 2'($urandom_range(0, 3));
         case (a_r)
            2'd0: d_r = int'($urandom_range(0, 2000)) - 2000;
            2'd1: d_r = int'($urandom_range(0, 2100)) - 100;
            2'd2: d_r = ($urandom_range(0, 12) == 0) ? 0
                        : int'(($urandom_range(16, 300) << 16) | $urandom_range(0, 65535));
            default: d_r = int'($urandom_range(0, 4));
         endcase
         st_r = ($urandom_range(0, 20) == 0);
         sp_r = ($urandom_range(0, 200) == 0);
         drive(we_r, a_r, 32'(d_r), st_r, sp_r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

Run controller for the triangle-wave `Sweep` generator.
- Holds a host-writable shadow copy of the sweep configuration and drives `Sweep`'s `on_in`, `minval_in`, `maxval_in` and `stepsize_in` from an active copy.
- Applies shadow changes atomically at sweep turnarounds.
- Counts completed periods, stops after a programmed number of cycles, and emits a per-period trigger for acquisition.
- Sits between the host register bus and one `Sweep` instance, and observes that instance's `signal_out`.

## Interface
Parameters:
- `CNT_W`, default 16: width of the cycle limit and cycle counter.

Ports:
- `clk_in`  in  1  system clock; everything is on its rising edge.
- `rst_n_in`  in  1  reset, asynchronous and active-low.
- `cfg_we_in`  in  1  shadow register write strobe.
- `cfg_addr_in`  in  2  register address: 0 = minval, 1 = maxval, 2 = stepsize, 3 = num_cycles.
- `cfg_data_in`  in  32  write data; 16-bit registers take bits [15:0] and `num_cycles` takes [CNT_W-1:0].
- `start_in`  in  1  start request, level-sampled.
- `stop_in`  in  1  abort request, level-sampled.
- `sweep_signal_in`  in  signed 16  `Sweep.signal_out`, with `SIGNAL_OUT_SIZE` = 16.
- `sweep_on_out`  out  1  to `Sweep.on_in`.
- `minval_out`, `maxval_out`  out  signed 16 each  active limits.
- `stepsize_out`  out  32  active step.
- `busy_out`  out  1  high while in RUN.
- `trig_out`  out  1  one-cycle pulse at each bottom turnaround.
- `done_out`  out  1  one-cycle pulse when the cycle limit is reached.
- `err_out`  out  1  one-cycle pulse when a configuration is rejected.
- `cycle_count_out`  out  CNT_W  completed periods in the current run.

## Operation
State machine: IDLE and RUN.

Common rules:
- All outputs are registered.
- Reset clears all shadow and active registers, all counters and all flags to 0, and sets the state to IDLE.
- A configuration is valid iff `minval < maxval` (signed compare) and `stepsize != 0`.
- Turnaround detection runs only in RUN:
  - Top event: `sweep_signal_in == maxval_out` while the previous sample was not equal to `maxval_out`. It sets `seen_top`.
  - Bottom event: `sweep_signal_in == minval_out`, not equal on the previous sample, and `seen_top` = 1. It clears `seen_top`.
  - The `seen_top` qualification suppresses a false bottom event from the initial value 0 when `minval` = 0.
- A shadow write sets the `pending` flag.

IDLE:
- `sweep_on_out` = 0.
- `start_in` with a valid shadow: copy shadow to active, clear `cycle_count_out`, `seen_top` and `pending`, enter RUN.
- `start_in` with an invalid shadow: pulse `err_out` and remain in IDLE.

RUN (`sweep_on_out` = 1, `busy_out` = 1):
- Bottom event:
  - `cycle_count_out` increments.
  - `trig_out` pulses.
  - If active `num_cycles` != 0 and the incremented count equals it: pulse `done_out` and go to IDLE. Active registers and the count hold their values.
  - Otherwise, if `pending` is set: copy shadow to active and clear `pending` if the shadow is valid; if it is invalid, pulse `err_out`, clear `pending` and keep the active values.
- `stop_in`: go to IDLE immediately. No `done_out` pulse, count holds.
- `start_in`: ignored.
- `num_cycles` = 0 means run until stopped. The counter wraps at 2^CNT_W without producing `done_out`.

Simultaneous events:
- `start_in` and `stop_in` together: stop wins.
- `stop_in` together with a bottom event: stop wins, but `trig_out` and the count increment still occur.
- A shadow write in the same cycle as an apply: the apply uses the pre-write shadow contents, and `pending` stays set so the new value is applied at the next bottom event.
- Writes in IDLE land only in shadow. Active values change only on start or on an apply in RUN.

## Timing
- Shadow write at edge t: visible in shadow at t+1.
- `start_in` sampled at edge t: `sweep_on_out`, the active values and `busy_out` change at t+1. `Sweep`'s output follows 2 cycles later; the sequencer does not depend on this latency.
- Event detection: `sweep_signal_in` at edge t → `trig_out`, `done_out`, count update and active-value update at t+1. The previous-sample register adds no extra latency.
- `stop_in` or a done condition at edge t: `sweep_on_out` = 0 at t+1.
- Asynchronous reset mid-run: `sweep_on_out` drops to 0 immediately and all pulses clear.

## Structure
- Package `sweep_seq_pkg` holds:
  - the state enum (IDLE, RUN);
  - register address constants (`ADDR_MIN`, `ADDR_MAX`, `ADDR_STEP`, `ADDR_NCYC`);
  - the configuration struct {min, max, step, ncyc}, shared by the shadow and active copies;
  - a `cfg_valid` function.
- One sub-module, `sweep_turn_detect`: the previous-sample registers plus the `seen_top` flag, producing top and bottom event pulses.

## Test plan
- Write min=-1000, max=1000, step=0x00400000, ncyc=3, then start. Required: 3 `trig_out` pulses, `done_out` coincident with the third, `sweep_on_out` = 0 the next cycle, `cycle_count_out` = 3.
- Shadow min=0, max=500, start. Required: no `trig_out` while the signal leaves 0; the first `trig_out` comes only after the top event at 500.
- Write max=2000 mid-run while rising. Required: `maxval_out` stays 1000 until the next bottom event, then becomes 2000 in the same cycle as `trig_out`.
- Start with min=100, max=100. Required: `err_out` pulse, state stays IDLE, `sweep_on_out` = 0. Repeat with step=0: same response.
- `stop_in` and `start_in` high together during RUN with ncyc=0. Required: IDLE next cycle and no `done_out`. A separate case asserts `rst_n_in` mid-run: all outputs 0 asynchronously.
- A shadow write in the same cycle as a bottom event with `pending` set. Required: the old shadow value is applied, and the new value is applied at the following bottom event.
